fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Redirect scheduler in front of the fetch-stage PC register.
- Arbitrates four redirect requesters: pipeline flush, branch misprediction, instruction realignment and function return.
- Holds the winning redirect until the fetch stage accepts it (the icache unblocks), and suppresses fetch output while any redirect is outstanding.
- Keeps saturating benchmark counters of redirects issued and requests dropped.

Parameters:
- PC_BITS, 32, width of every PC/address field
- CNT_BITS, 16, width of each benchmark counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_req  in  1  pipeline flush request (priority 3, highest)
- flush_pc  in  PC_BITS  flush target address
- mispred_req  in  1  branch misprediction redirect (priority 2)
- mispred_pc  in  PC_BITS  mispredict restart PC
- realign_req  in  1  invalid-instruction realignment redirect (priority 1)
- realign_pc  in  PC_BITS  realignment restart PC
- ret_req  in  1  function-return redirect (priority 0, lowest)
- ret_pc  in  PC_BITS  return target PC
- fetch_ack  in  1  fetch stage loads PC this cycle (icache hit)
- redir_valid  out  1  a pending redirect is presented
- redir_pc  out  PC_BITS  PC of the pending redirect
- redir_src  out  2  source of the pending redirect: 0 ret, 1 realign, 2 mispred, 3 flush
- kill_o  out  1  fetch output must be suppressed this cycle
- cnt_flush  out  CNT_BITS  flush redirects issued
- cnt_other  out  CNT_BITS  non-flush redirects issued
- cnt_drop  out  CNT_BITS  requests discarded by arbitration

Behaviour:
- Reset (asynchronous, rst_n low): pending state cleared. redir_valid=0, redir_pc=0, redir_src=0, all counters 0. Reset asserted mid-operation discards any pending redirect immediately; no redirect is issued after reset deasserts.
- States: IDLE (no pending), PEND (pending register holds {pc, src}).
- Same-cycle arbitration: of the requests asserted in one cycle, the highest priority wins. Every other asserted request increments cnt_drop; when several lose in one cycle, cnt_drop adds the number of losers (max 3).
- IDLE with a winner: go to PEND, latch the winner's pc/src. redir_valid rises the next cycle (1-cycle latency).
- IDLE with no request: stay in IDLE.
- PEND with fetch_ack=1: the redirect is consumed. Increment cnt_flush if src=3, else cnt_other.
  - If a new winner exists in the same cycle, it is latched unconditionally (stay in PEND).
  - Otherwise go to IDLE.
- PEND with fetch_ack=0 and a new winner:
  - If the winner's priority is strictly greater than the pending src, it replaces the pending entry and the replaced entry counts as a drop.
  - Otherwise the winner is dropped (cnt_drop +1).
  - Equal priority never replaces: the older redirect is kept.
- fetch_ack with no pending entry has no effect.
- redir_pc and redir_src hold their last value while redir_valid=0; the bench checks them only when redir_valid=1.
- kill_o = redir_valid | flush_req | mispred_req | realign_req | ret_req. It is combinational, so fetch output is suppressed in the request cycle itself.
- Counters saturate at all-ones and never wrap. Each counter updates at most once per cycle (cnt_drop by its summed increment, saturating).
- Multiplexers and comparators are pure combinational logic. All state is in flops with asynchronous reset.

Test Plan:
- Reset, then mispred_req=1, mispred_pc=0x100 for one cycle with fetch_ack=0 -> next cycle redir_valid=1, redir_pc=0x100, redir_src=2. Hold fetch_ack=0 for 3 cycles -> outputs stable. Assert fetch_ack -> redir_valid=0 next cycle, cnt_other=1.
- flush_req (0x2000) and ret_req (0x44) in the same cycle -> redir_pc=0x2000, redir_src=3, cnt_drop=1. After fetch_ack -> cnt_flush=1.
- Pending realign (0x80), fetch_ack=0, then flush_req (0x400) -> redir_pc=0x400, src=3, cnt_drop=1. A subsequent mispred_req -> dropped, pending unchanged, cnt_drop=2.
- Pending mispred (0x10) with fetch_ack=1 and ret_req (0x20) in the same cycle -> next cycle redir_valid=1, pc=0x20, src=0, cnt_other=1.
- ret_req pulse -> kill_o=1 in the same cycle and every following cycle until the ack cycle inclusive; kill_o=0 the cycle after the ack.
- Pending flush, pulse rst_n low mid-cycle -> redir_valid=0 and all counters 0 immediately. Release reset with no requests -> redir_valid stays 0.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Redirect scheduler in front of the fetch-stage PC register.
// Arbitrates four redirect sources, holds the winner until fetch accepts it.
module fetch_redirect_ctrl #(
    parameter int PC_BITS  = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_req,
    input  logic [PC_BITS-1:0]  flush_pc,
    input  logic                mispred_req,
    input  logic [PC_BITS-1:0]  mispred_pc,
    input  logic                realign_req,
    input  logic [PC_BITS-1:0]  realign_pc,
    input  logic                ret_req,
    input  logic [PC_BITS-1:0]  ret_pc,
    input  logic                fetch_ack,
    output logic                redir_valid,
    output logic [PC_BITS-1:0]  redir_pc,
    output logic [1:0]          redir_src,
    output logic                kill_o,
    output logic [CNT_BITS-1:0] cnt_flush,
    output logic [CNT_BITS-1:0] cnt_other,
    output logic [CNT_BITS-1:0] cnt_drop
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state, state_nx;
    logic [PC_BITS-1:0] pend_pc, pend_pc_nx;
    logic [1:0]         pend_src, pend_src_nx;

    logic               win_any;
    logic [PC_BITS-1:0] win_pc;
    logic [1:0]         win_src;
    logic [2:0]         nreq;
    logic [2:0]         drop_inc;
    logic               inc_flush, inc_other;

    logic [CNT_BITS:0]  drop_sum;
    logic [CNT_BITS:0]  flush_sum;
    logic [CNT_BITS:0]  other_sum;

    // Fixed-priority winner of this cycle's requests and request count
    always_comb begin
        win_any = 1'b1;
        win_pc  = ret_pc;
        win_src = 2'd0;
        if (flush_req) begin
            win_pc  = flush_pc;
            win_src = 2'd3;
        end else if (mispred_req) begin
            win_pc  = mispred_pc;
            win_src = 2'd2;
        end else if (realign_req) begin
            win_pc  = realign_pc;
            win_src = 2'd1;
        end else if (!ret_req) begin
            win_any = 1'b0;
        end
        nreq = {2'b0, flush_req} + {2'b0, mispred_req}
             + {2'b0, realign_req} + {2'b0, ret_req};
    end

    // Next pending entry, drop accounting and consume events
    always_comb begin
        state_nx    = state;
        pend_pc_nx  = pend_pc;
        pend_src_nx = pend_src;
        inc_flush   = 1'b0;
        inc_other   = 1'b0;
        drop_inc    = win_any ? nreq - 3'd1 : 3'd0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    state_nx    = PEND;
                    pend_pc_nx  = win_pc;
                    pend_src_nx = win_src;
                end
            end
            PEND: begin
                if (fetch_ack) begin
                    inc_flush = (pend_src == 2'd3);
                    inc_other = (pend_src != 2'd3);
                    if (win_any) begin
                        pend_pc_nx  = win_pc;
                        pend_src_nx = win_src;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (win_any) begin
                    // Either the old entry or the new winner is lost
                    drop_inc = drop_inc + 3'd1;
                    if (win_src > pend_src) begin
                        pend_pc_nx  = win_pc;
                        pend_src_nx = win_src;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign drop_sum  = {1'b0, cnt_drop}
                     + {{(CNT_BITS-2){1'b0}}, drop_inc};
    assign flush_sum = {1'b0, cnt_flush} + {{CNT_BITS{1'b0}}, inc_flush};
    assign other_sum = {1'b0, cnt_other} + {{CNT_BITS{1'b0}}, inc_other};

    // Pending register and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend_pc  <= '0;
            pend_src <= '0;
        end else begin
            state    <= state_nx;
            pend_pc  <= pend_pc_nx;
            pend_src <= pend_src_nx;
        end
    end

    // Saturating benchmark counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_flush <= '0;
            cnt_other <= '0;
            cnt_drop  <= '0;
        end else begin
            cnt_flush <= flush_sum[CNT_BITS] ? '1 : flush_sum[CNT_BITS-1:0];
            cnt_other <= other_sum[CNT_BITS] ? '1 : other_sum[CNT_BITS-1:0];
            cnt_drop  <= drop_sum[CNT_BITS]  ? '1 : drop_sum[CNT_BITS-1:0];
        end
    end

    assign redir_valid = (state == PEND);
    assign redir_pc    = pend_pc;
    assign redir_src   = pend_src;
    assign kill_o      = redir_valid | flush_req | mispred_req
                       | realign_req | ret_req;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed redirect scenarios.
// Consumed redirects are checked by a monitor; state by inline checks.
module tb_fetch_redirect_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush_req = 0, mispred_req = 0, realign_req = 0, ret_req = 0;
    logic [31:0] flush_pc = 0, mispred_pc = 0, realign_pc = 0, ret_pc = 0;
    logic        fetch_ack = 0;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [1:0]  redir_src;
    logic        kill_o;
    logic [15:0] cnt_flush, cnt_other, cnt_drop;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    fetch_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .mispred_req(mispred_req), .mispred_pc(mispred_pc),
        .realign_req(realign_req), .realign_pc(realign_pc),
        .ret_req(ret_req), .ret_pc(ret_pc),
        .fetch_ack(fetch_ack),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_src(redir_src), .kill_o(kill_o),
        .cnt_flush(cnt_flush), .cnt_other(cnt_other), .cnt_drop(cnt_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush_req = 0;
        mispred_req = 0;
        realign_req = 0;
        ret_req = 0;
    endtask

    task automatic ack_one();
        fetch_ack = 1;
        step();
        fetch_ack = 0;
        #1;
    endtask

    // Monitor: every accepted redirect must match the scoreboard head
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && redir_valid && fetch_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected: got pc 0x%0h src %0d, queue empty",
                             redir_pc, redir_src);
                end else begin
                    e = exp_q.pop_front();
                    if ({redir_pc, redir_src} !== e) begin
                        errors++;
                        $display("FAIL accept: got pc 0x%0h src %0d expected pc 0x%0h src %0d",
                                 redir_pc, redir_src, e[33:2], e[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_valid", redir_valid, 0);
        chk("rst_pc", redir_pc, 0);
        chk("rst_drop", cnt_drop, 0);
        rst_n = 1;
        step();

        // Mispredict, held without ack
        mispred_req = 1; mispred_pc = 32'h100;
        #1 chk("kill_req_cycle", kill_o, 1);
        chk("valid_latency0", redir_valid, 0);
        step(); clr(); #1;
        chk("mp_valid", redir_valid, 1);
        chk("mp_pc", redir_pc, 32'h100);
        chk("mp_src", redir_src, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mp_hold_pc", redir_pc, 32'h100);
            chk("mp_hold_valid", redir_valid, 1);
        end
        exp_q.push_back({32'h100, 2'd2});
        ack_one();
        chk("mp_done_valid", redir_valid, 0);
        chk("mp_cnt_other", cnt_other, 1);

        // Flush beats return in the same cycle
        flush_req = 1; flush_pc = 32'h2000;
        ret_req = 1; ret_pc = 32'h44;
        step(); clr(); #1;
        chk("fr_pc", redir_pc, 32'h2000);
        chk("fr_src", redir_src, 3);
        chk("fr_drop", cnt_drop, 1);
        exp_q.push_back({32'h2000, 2'd3});
        ack_one();
        chk("fr_cnt_flush", cnt_flush, 1);

        // Higher priority replaces, lower is dropped
        realign_req = 1; realign_pc = 32'h80;
        step(); clr(); #1;
        chk("ra_src", redir_src, 1);
        flush_req = 1; flush_pc = 32'h400;
        step(); clr(); #1;
        chk("rep_pc", redir_pc, 32'h400);
        chk("rep_src", redir_src, 3);
        chk("rep_drop", cnt_drop, 2);
        mispred_req = 1; mispred_pc = 32'h999;
        step(); clr(); #1;
        chk("low_pc", redir_pc, 32'h400);
        chk("low_drop", cnt_drop, 3);
        exp_q.push_back({32'h400, 2'd3});
        ack_one();
        chk("rep_cnt_flush", cnt_flush, 2);

        // Equal priority keeps older; ack plus new request chains
        mispred_req = 1; mispred_pc = 32'h10;
        step(); clr();
        mispred_req = 1; mispred_pc = 32'h30;
        step(); clr(); #1;
        chk("eq_pc", redir_pc, 32'h10);
        chk("eq_drop", cnt_drop, 4);
        exp_q.push_back({32'h10, 2'd2});
        fetch_ack = 1; ret_req = 1; ret_pc = 32'h20;
        step(); clr(); fetch_ack = 0; #1;
        chk("ch_valid", redir_valid, 1);
        chk("ch_pc", redir_pc, 32'h20);
        chk("ch_src", redir_src, 0);
        chk("ch_cnt_other", cnt_other, 2);
        exp_q.push_back({32'h20, 2'd0});
        ack_one();
        chk("ch_cnt_other2", cnt_other, 3);

        // kill_o window of a return redirect
        chk("kill_idle", kill_o, 0);
        ret_req = 1; ret_pc = 32'h44;
        #1 chk("kill_t0", kill_o, 1);
        step(); clr(); #1;
        chk("kill_t1", kill_o, 1);
        step();
        chk("kill_t2", kill_o, 1);
        exp_q.push_back({32'h44, 2'd0});
        fetch_ack = 1;
        #1 chk("kill_ack", kill_o, 1);
        step(); fetch_ack = 0; #1;
        chk("kill_after", kill_o, 0);
        chk("kill_cnt_other", cnt_other, 4);

        // Asynchronous reset discards pending flush
        flush_req = 1; flush_pc = 32'h500;
        step(); clr(); #1;
        chk("pre_rst_valid", redir_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_valid", redir_valid, 0);
        chk("arst_flush", cnt_flush, 0);
        chk("arst_other", cnt_other, 0);
        chk("arst_drop", cnt_drop, 0);
        #3 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", redir_valid, 0);
        end

        // Drop counter saturation
        flush_req = 1; flush_pc = 32'h600;
        mispred_req = 1; realign_req = 1; ret_req = 1;
        for (int i = 0; i < 16500; i++) step();
        clr(); #1;
        chk("sat_drop", cnt_drop, 32'hFFFF);
        chk("sat_pc", redir_pc, 32'h600);
        exp_q.push_back({32'h600, 2'd3});
        ack_one();
        chk("sat_cnt_flush", cnt_flush, 1);
        chk("sat_drop_hold", cnt_drop, 32'hFFFF);

        step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
